vmproj_reader: RTL and testbench

VMPROJ_READER -- requirements
Module: vmproj_reader

---
 rtl/vmproj_reader.sv | 171 +++++++++++++++++
 tb/tb_vmproj_reader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vmproj_reader.sv
// Reads one page of projection words per BX and streams them out through a skid FIFO.
// Latency: 3 clocks start-to-first-read, READ_LAT+1 clocks read-to-FIFO; backpressure via ready_in, reads throttled to FIFO space.

module vmproj_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push_vld,
  input  logic [W-1:0]                 push_dat,
  input  logic                         pop_rdy,
  output logic                         head_vld,
  output logic [W-1:0]                 head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr];
  assign pop      = pop_rdy && head_vld;
  assign push     = push_vld && ((count != CW'(DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end
endmodule

module vmproj_reader #(
  parameter int MEM_SIZE = 5,
  parameter int TMUX     = 18,
  parameter int READ_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_proc,
  input  logic [1:0]            start,
  output logic [1:0]            done,
  input  logic [5:0]            number_in,
  output logic [MEM_SIZE+2:0]   read_add,
  input  logic [13:0]           data_in,
  output logic [13:0]           data_out,
  output logic                  valid_out,
  input  logic                  ready_in
);
  localparam int IW           = MEM_SIZE + 1;
  localparam int DEPTH        = READ_LAT + 2;
  localparam int PAGE_ENTRIES = 1 << MEM_SIZE;
  localparam int CW           = $clog2(DEPTH+1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ} state_t;

  state_t              state, state_nxt;
  logic [2:0]          bx;
  logic [1:0]          wait_cnt;
  logic [IW-1:0]       idx, n_lim, lim_w;
  logic                rd_vld;
  logic [READ_LAT-1:0] tag;
  logic                flush, issue, load;
  logic [CW-1:0]       fifo_cnt;
  logic [13:0]         head_dat;
  int                  inflight;
  logic [1:0]          done_pipe [TMUX];

  assign flush = start[0] || start[1];
  assign lim_w = (int'(number_in) > PAGE_ENTRIES) ? IW'(PAGE_ENTRIES) : IW'(number_in);

  always_comb begin
    inflight = int'(rd_vld);
    for (int i = 0; i < READ_LAT; i++) inflight += int'(tag[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_IDLE;
      S_WAIT: if (wait_cnt == 2'd0) state_nxt = (lim_w == '0) ? S_IDLE : S_READ;
      S_READ: if (idx == n_lim && inflight == 0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (start[0]) state_nxt = S_WAIT;
    if (start[1]) state_nxt = S_IDLE;
  end

  // Issue only while every outstanding read is guaranteed a FIFO slot.
  always_comb begin
    issue = 1'b0;
    load  = 1'b0;
    if (state == S_WAIT && wait_cnt == 2'd0) load = 1'b1;
    if (state == S_READ && !flush && en_proc && idx < n_lim &&
        (inflight + int'(fifo_cnt)) < DEPTH)
      issue = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || start[1])  bx <= 3'b111;
    else if (start[0])      bx <= bx + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      idx      <= '0;
      n_lim    <= '0;
      read_add <= '0;
      rd_vld   <= 1'b0;
      tag      <= '0;
    end else begin
      rd_vld <= issue;
      tag    <= flush ? '0 : ((tag << 1) | READ_LAT'(rd_vld));
      if (start[0])                            wait_cnt <= 2'd2;
      else if (state == S_WAIT && wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;
      if (load) begin
        n_lim <= lim_w;
        idx   <= '0;
      end else if (issue) begin
        idx   <= idx + 1'b1;
      end
      // Page is the one the writer filled last BX; index never exceeds the page.
      if (issue) read_add <= {2'b00, ~bx[0], idx[MEM_SIZE-1:0]};
    end
  end

  vmproj_fifo #(.W(14), .DEPTH(DEPTH)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push_vld (tag[READ_LAT-1] && !flush),
    .push_dat (data_in),
    .pop_rdy  (ready_in),
    .head_vld (valid_out),
    .head_dat (head_dat),
    .count    (fifo_cnt)
  );

  assign data_out = valid_out ? head_dat : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TMUX; i++) done_pipe[i] <= '0;
    end else begin
      done_pipe[0] <= start;
      for (int i = 1; i < TMUX; i++) done_pipe[i] <= done_pipe[i-1];
    end
  end

  assign done = done_pipe[TMUX-1];
endmodule

// File: tb/tb_vmproj_reader.sv
// Bench for vmproj_reader: random memory contents and handshake patterns against a page/queue reference model.
module tb_vmproj_reader;
  localparam int MEM_SIZE = 5;
  localparam int TMUX     = 18;
  localparam int READ_LAT = 2;
  localparam int AW       = MEM_SIZE + 3;

  logic          clk = 1'b0;
  logic          reset, en_proc, ready_in;
  logic [1:0]    start, done;
  logic [5:0]    number_in;
  logic [AW-1:0] read_add;
  logic [13:0]   data_in, data_out;
  logic          valid_out;

  vmproj_reader #(.MEM_SIZE(MEM_SIZE), .TMUX(TMUX), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .reset(reset), .en_proc(en_proc), .start(start), .done(done),
    .number_in(number_in), .read_add(read_add), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in)
  );

  always #5 clk = ~clk;

  // Projection memory with READ_LAT clocks from address to data.
  logic [13:0] mem_m [1 << AW];
  logic [13:0] pipe  [READ_LAT];
  always @(posedge clk) begin
    pipe[0] <= mem_m[read_add];
    for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign data_in = pipe[READ_LAT-1];

  int          checks = 0;
  int          errors = 0;
  int          bx_m;
  int          cur_page, cur_n, accepted;
  logic [13:0] expq [$];
  logic [1:0]  dq [$];
  logic        hold_pend = 1'b0;
  logic [13:0] held;
  logic        checking = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_done_model();
    dq.delete();
    for (int i = 0; i < TMUX; i++) dq.push_back(2'b00);
  endtask

  // A new pass: min(number_in, page size) words from the page opposite bx[0].
  task automatic fill();
    cur_page = ((bx_m & 1) == 0) ? 1 : 0;
    cur_n    = (int'(number_in) > (1 << MEM_SIZE)) ? (1 << MEM_SIZE) : int'(number_in);
    for (int i = 0; i < cur_n; i++) expq.push_back(mem_m[(cur_page << MEM_SIZE) + i]);
  endtask

  task automatic check_outputs();
    logic [31:0] exp_w;
    if (!checking) return;
    chk("done", 32'(done), 32'(dq[0]));
    if (hold_pend) begin
      chk("hold_vld", 32'(valid_out), 32'd1);
      chk("hold_dat", 32'(data_out), 32'(held));
      hold_pend = 1'b0;
    end
    if (valid_out === 1'b1 && ready_in) begin
      exp_w = (expq.size() > 0) ? 32'(expq.pop_front()) : 32'hFFFF_FFFF;
      chk("word", 32'(data_out), exp_w);
      accepted++;
    end else if (valid_out === 1'b1) begin
      held      = data_out;
      hold_pend = 1'b1;
    end
  endtask

  task automatic step();
    check_outputs();
    @(posedge clk);
    if (reset) begin
      bx_m = 7;
      expq.delete();
      hold_pend = 1'b0;
      reset_done_model();
    end else begin
      dq.push_back(start);
      void'(dq.pop_front());
      if (start[1]) begin
        bx_m = 7;
        expq.delete();
        hold_pend = 1'b0;
      end else if (start[0]) begin
        bx_m = (bx_m + 1) % 8;
        expq.delete();
        hold_pend = 1'b0;
        fill();
      end
    end
    @(negedge clk);
  endtask

  function automatic logic pick_ready(input int mode, input int cyc);
    logic [3:0] pat;
    pat = 4'b1001;
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[3 - (cyc % 4)];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_pass(input int num, input int rmode, input int emode, input int stop_after);
    int            cyc;
    logic [AW-1:0] prev_add;
    prev_add  = read_add;
    number_in = 6'(num);
    start     = 2'b01;
    en_proc   = 1'b1;
    ready_in  = 1'b1;
    step();
    start    = 2'b00;
    accepted = 0;
    cyc      = 0;
    while (expq.size() > 0 && cyc < 3000 && !(stop_after > 0 && accepted >= stop_after)) begin
      ready_in = pick_ready(rmode, cyc);
      en_proc  = (emode != 0) ? ($urandom_range(0, 9) < 7) : 1'b1;
      step();
      cyc++;
    end
    if (stop_after == 0) begin
      chk("pass_drained", 32'(expq.size()), 32'd0);
      ready_in = 1'b1;
      en_proc  = 1'b1;
      repeat (20) step();
      if (cur_n > 0) chk("last_addr", 32'(read_add), 32'((cur_page << MEM_SIZE) + cur_n - 1));
      else           chk("no_read", 32'(read_add), 32'(prev_add));
      chk("idle_vld", 32'(valid_out), 32'd0);
    end else begin
      chk("abort_point", 32'(accepted), 32'(stop_after));
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem_m[i] = 14'($urandom);
    for (int i = 0; i < READ_LAT; i++) pipe[i] = '0;
    reset = 1'b1; start = 2'b00; en_proc = 1'b0; ready_in = 1'b0; number_in = '0;
    bx_m = 7;
    reset_done_model();
    @(negedge clk);
    repeat (3) step();
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_add", 32'(read_add), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset    = 1'b0;
    checking = 1'b1;
    step();

    run_pass(5, 0, 0, 0);
    chk("first_page", 32'(read_add[MEM_SIZE]), 32'd1);
    run_pass(5, 1, 0, 0);
    run_pass(0, 2, 0, 0);
    run_pass(63, 2, 1, 0);
    chk("full_page_last", 32'(read_add[MEM_SIZE-1:0]), 32'((1 << MEM_SIZE) - 1));
    run_pass(8, 0, 0, 3);
    run_pass(8, 0, 0, 0);

    start = 2'b10;
    step();
    start = 2'b00;
    repeat (3) step();
    run_pass(6, 2, 0, 0);
    chk("page_after_clr", 32'(read_add[MEM_SIZE]), 32'd1);

    for (int k = 0; k < 5; k++) run_pass(int'($urandom_range(0, 40)), 2, 1, 0);
    repeat (TMUX + 2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
